// File: rtl/bin_to_bcd_seq_if.sv
// Handshake and result bundle for the sequential binary-to-BCD converter.
// The requester drives start/binary; the converter returns busy/done/bcd/overflow.
interface bin_to_bcd_seq_if #(
    parameter int BIN_W  = 12,
    parameter int DIGITS = 4
);
    logic                  start;
    logic [BIN_W-1:0]      binary;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  overflow;

    modport master (
        output start,
        output binary,
        input  busy,
        input  done,
        input  bcd,
        input  overflow
    );

    modport slave (
        input  start,
        input  binary,
        output busy,
        output done,
        output bcd,
        output overflow
    );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter.
// One bit is consumed per clock, so a conversion always takes exactly BIN_W
// shift cycles regardless of the data. Results are held in output registers
// that only change on the done edge; a 1 carried out of the top digit marks
// the result as truncated (value mod 10^DIGITS).
module bin_to_bcd_seq #(
    parameter int BIN_W  = 12,
    parameter int DIGITS = 4
) (
    input  logic             clk,
    input  logic             reset,
    bin_to_bcd_seq_if.slave  bus
);

    localparam int DW    = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t             state_r;
    logic [BIN_W-1:0]   shift_r;
    logic [DW-1:0]      digits_r;
    logic               ovf_acc_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               busy_r;
    logic               done_r;
    logic [DW-1:0]      bcd_r;
    logic               overflow_r;

    logic [DW-1:0]      adj_s;
    logic [DW-1:0]      digits_nxt_s;
    logic [BIN_W-1:0]   shift_nxt_s;
    logic               carry_out_s;
    logic               last_step_s;
    logic               ovf_nxt_s;

    // Double-dabble correction: a digit of 5 or more gets +3 so that the
    // following left shift carries correctly into the next decimal digit.
    function automatic logic [3:0] dabble_adj(input logic [3:0] d);
        if (d >= 4'd5) begin
            return d + 4'd3;
        end else begin
            return d;
        end
    endfunction

    // One double-dabble step computed from the current working registers.
    always_comb begin
        adj_s = '0;
        for (int k = 0; k < DIGITS; k++) begin
            adj_s[4*k +: 4] = dabble_adj(digits_r[4*k +: 4]);
        end
        carry_out_s  = adj_s[DW-1];
        digits_nxt_s = {adj_s[DW-2:0], shift_r[BIN_W-1]};
        shift_nxt_s  = shift_r << 1;
        last_step_s  = (cnt_r == CNT_W'(1));
        ovf_nxt_s    = ovf_acc_r | carry_out_s;
    end

    // Control FSM together with the datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            shift_r    <= '0;
            digits_r   <= '0;
            ovf_acc_r  <= 1'b0;
            cnt_r      <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            bcd_r      <= '0;
            overflow_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        shift_r   <= bus.binary;
                        digits_r  <= '0;
                        ovf_acc_r <= 1'b0;
                        cnt_r     <= CNT_W'(BIN_W);
                        busy_r    <= 1'b1;
                        state_r   <= ST_SHIFT;
                    end else begin
                        busy_r    <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    shift_r   <= shift_nxt_s;
                    digits_r  <= digits_nxt_s;
                    ovf_acc_r <= ovf_nxt_s;
                    cnt_r     <= cnt_r - CNT_W'(1);
                    if (last_step_s) begin
                        // Final step: publish the result and go back to idle.
                        state_r    <= ST_IDLE;
                        busy_r     <= 1'b0;
                        done_r     <= 1'b1;
                        bcd_r      <= digits_nxt_s;
                        overflow_r <= ovf_nxt_s;
                    end else begin
                        busy_r     <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.bcd      = bcd_r;
    assign bus.overflow = overflow_r;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: a default (12-bit, 4-digit) instance
// and a 12-bit, 3-digit instance, checked against an arithmetic decimal model.
module tb_bin_to_bcd_seq;

    logic clk;
    logic reset;

    int checks = 0;
    int errors = 0;

    logic [63:0] prev_bcd [2];
    logic        prev_ovf [2];

    bin_to_bcd_seq_if #(.BIN_W(12), .DIGITS(4)) b4 ();
    bin_to_bcd_seq_if #(.BIN_W(12), .DIGITS(3)) b3 ();

    bin_to_bcd_seq #(.BIN_W(12), .DIGITS(4)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (b4)
    );

    bin_to_bcd_seq #(.BIN_W(12), .DIGITS(3)) u_dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (b3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Decimal digits of v, low nd digits only (v mod 10^nd), by plain division.
    function automatic logic [63:0] ref_bcd(input longint v, input int nd);
        logic [63:0] r;
        longint      x;
        r = '0;
        x = v;
        for (int k = 0; k < nd; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic ref_ovf(input longint v, input int nd);
        longint lim;
        lim = 1;
        for (int k = 0; k < nd; k++) lim = lim * 10;
        return (v >= lim);
    endfunction

    function automatic logic [63:0] obs_busy(input bit sel);
        return sel ? 64'(b3.busy) : 64'(b4.busy);
    endfunction

    function automatic logic [63:0] obs_done(input bit sel);
        return sel ? 64'(b3.done) : 64'(b4.done);
    endfunction

    function automatic logic [63:0] obs_bcd(input bit sel);
        return sel ? 64'(b3.bcd) : 64'(b4.bcd);
    endfunction

    function automatic logic [63:0] obs_ovf(input bit sel);
        return sel ? 64'(b3.overflow) : 64'(b4.overflow);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s mismatch", tag);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full conversion on the selected instance; optionally pulses a
    // competing start (binary=456) in cycle 5, which must be ignored.
    task automatic conv(input bit sel, input int value, input bit glitch);
        logic [63:0] exp_b;
        logic        exp_o;
        int          nd;
        int          s;
        s     = sel ? 1 : 0;
        nd    = sel ? 3 : 4;
        exp_b = ref_bcd(longint'(value), nd);
        exp_o = ref_ovf(longint'(value), nd);
        if (sel) begin
            b3.start  = 1'b1;
            b3.binary = 12'(value);
        end else begin
            b4.start  = 1'b1;
            b4.binary = 12'(value);
        end
        step();
        for (int i = 1; i <= 12; i++) begin
            if (sel) begin
                b3.start = 1'b0;
            end else begin
                b4.start = (glitch && i == 5);
                if (glitch && i == 5) b4.binary = 12'd456;
            end
            check("busy_high", obs_busy(sel), 64'd1);
            check("done_low", obs_done(sel), 64'd0);
            check("bcd_hold", obs_bcd(sel), prev_bcd[s]);
            check("ovf_hold", obs_ovf(sel), 64'(prev_ovf[s]));
            step();
        end
        b3.start = 1'b0;
        b4.start = 1'b0;
        check("done_pulse", obs_done(sel), 64'd1);
        check("busy_end", obs_busy(sel), 64'd0);
        check("bcd_result", obs_bcd(sel), exp_b);
        check("ovf_result", obs_ovf(sel), 64'(exp_o));
        prev_bcd[s] = exp_b;
        prev_ovf[s] = exp_o;
        step();
        check("done_one_cycle", obs_done(sel), 64'd0);
    endtask

    initial begin
        int acc;
        int nxt;
        logic [63:0] exp_b;

        prev_bcd[0] = '0;
        prev_bcd[1] = '0;
        prev_ovf[0] = 1'b0;
        prev_ovf[1] = 1'b0;

        // Reset with start asserted: start must be ignored.
        reset     = 1'b1;
        b4.start  = 1'b1;
        b4.binary = 12'd5;
        b3.start  = 1'b0;
        b3.binary = 12'd0;
        step();
        step();
        reset    = 1'b0;
        b4.start = 1'b0;
        check("rst_busy4", obs_busy(1'b0), 64'd0);
        check("rst_done4", obs_done(1'b0), 64'd0);
        check("rst_bcd4", obs_bcd(1'b0), 64'd0);
        check("rst_ovf4", obs_ovf(1'b0), 64'd0);
        check("rst_busy3", obs_busy(1'b1), 64'd0);
        check("rst_bcd3", obs_bcd(1'b1), 64'd0);
        step();
        check("start_in_reset_ignored", obs_busy(1'b0), 64'd0);

        // Default-size directed values.
        conv(1'b0, 4095, 1'b0);
        conv(1'b0, 0, 1'b0);
        conv(1'b0, 999, 1'b0);

        // Three-digit instance: overflow boundary.
        conv(1'b1, 1000, 1'b0);
        conv(1'b1, 999, 1'b0);

        // Competing start in cycle 5 is ignored; no second done follows.
        conv(1'b0, 123, 1'b1);
        for (int i = 0; i < 14; i++) begin
            check("no_extra_done", obs_done(1'b0), 64'd0);
            check("no_extra_busy", obs_busy(1'b0), 64'd0);
            step();
        end

        // Reset in cycle 6 aborts the conversion with no done pulse.
        b4.start  = 1'b1;
        b4.binary = 12'd777;
        step();
        b4.start = 1'b0;
        for (int i = 1; i <= 5; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_busy", obs_busy(1'b0), 64'd0);
        check("abort_bcd", obs_bcd(1'b0), 64'd0);
        check("abort_ovf", obs_ovf(1'b0), 64'd0);
        prev_bcd[0] = '0;
        prev_bcd[1] = '0;
        prev_ovf[0] = 1'b0;
        prev_ovf[1] = 1'b0;
        for (int i = 0; i < 14; i++) begin
            check("abort_no_done", obs_done(1'b0), 64'd0);
            step();
        end
        conv(1'b0, 42, 1'b0);

        // start held high: a result every 13 cycles from the value sampled
        // at each accepting edge, while binary churns during the shifts.
        acc       = int'($urandom_range(0, 4095));
        b4.start  = 1'b1;
        b4.binary = 12'(acc);
        step();
        for (int n = 0; n < 4; n++) begin
            for (int i = 1; i <= 12; i++) begin
                b4.binary = 12'($urandom_range(0, 4095));
                check("b2b_busy", obs_busy(1'b0), 64'd1);
                check("b2b_done_low", obs_done(1'b0), 64'd0);
                step();
            end
            exp_b = ref_bcd(longint'(acc), 4);
            check("b2b_done", obs_done(1'b0), 64'd1);
            check("b2b_bcd", obs_bcd(1'b0), exp_b);
            check("b2b_ovf", obs_ovf(1'b0), 64'd0);
            prev_bcd[0] = exp_b;
            prev_ovf[0] = 1'b0;
            nxt       = int'($urandom_range(0, 4095));
            b4.binary = 12'(nxt);
            if (n == 3) b4.start = 1'b0;
            acc = nxt;
            step();
        end
        check("b2b_stop_busy", obs_busy(1'b0), 64'd0);
        check("b2b_stop_done", obs_done(1'b0), 64'd0);

        // Randomized values on both instances.
        for (int n = 0; n < 6; n++) begin
            conv(1'b0, int'($urandom_range(0, 4095)), 1'b0);
            conv(1'b1, int'($urandom_range(0, 4095)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_seq.md
BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
REQ-001 The block SHALL have parameter BIN_W, default 12, giving the binary input width; legal range 1..32.
REQ-002 The block SHALL have parameter DIGITS, default 4, giving the number of BCD output digits; legal range 1..10.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port start, input, 1, a conversion request; sampled only when idle.
REQ-006 The block SHALL have port binary, input, BIN_W, the unsigned value to convert; sampled only on the accepting edge.
REQ-007 The block SHALL have port busy, output, 1, high while a conversion is in progress.
REQ-008 The block SHALL have port done, output, 1, a one-cycle pulse marking a new result on bcd and overflow.
REQ-009 The block SHALL have port bcd, output, 4*DIGITS, the result; digit k in bits [4k+3:4k], with digit 0 the ones digit.
REQ-010 The block SHALL have port overflow, output, 1, high when the last result exceeded 10^DIGITS-1.

Function
REQ-011 The block SHALL implement a two-state FSM: IDLE (busy=0) and SHIFT (busy=1).
REQ-012 In IDLE with start=1 at edge E0, the block SHALL latch binary into a shift register, clear the working digits and overflow accumulator, load a counter with BIN_W, and enter SHIFT.
REQ-013 Each SHIFT cycle SHALL perform one double-dabble step: every working digit >=5 gets +3 (4-bit, no carry between digits), then {digits, shift register} shifts left one bit with the binary MSB entering digit 0 bit 0.
REQ-014 Any 1 shifted out of the top digit bit 3 SHALL set a sticky overflow accumulator for the current conversion.
REQ-015 The counter SHALL decrement once per SHIFT cycle; the edge completing the BIN_W-th step SHALL return the FSM to IDLE.
REQ-016 On that same edge, bcd SHALL load the final digits, overflow SHALL load the accumulator, and done SHALL go high for exactly one cycle.
REQ-017 Latency SHALL be fixed: start sampled at edge E0, busy high for cycles 1..BIN_W, done and the valid result present in cycle BIN_W+1, independent of the data value.
REQ-018 bcd and overflow SHALL hold the previous result throughout a conversion and change only on the done edge.
REQ-019 start SHALL be ignored while busy=1; no queuing, and binary changes during SHIFT SHALL have no effect.
REQ-020 start=1 in the cycle where done=1 (FSM already IDLE) SHALL be accepted, allowing back-to-back conversions every BIN_W+1 cycles.
REQ-021 On overflow, bcd SHALL equal the low DIGITS decimal digits of the value, i.e. value mod 10^DIGITS.
REQ-022 Each digit of bcd SHALL always be in 0..9.

Reset
REQ-023 With reset=1 at a rising edge, the block SHALL enter IDLE and clear busy, done, overflow, bcd, the counter and all working registers to 0.
REQ-024 reset SHALL take priority over start and over any in-progress conversion; an aborted conversion SHALL produce no done pulse.
REQ-025 start sampled together with reset=1 SHALL be ignored.

Verification
REQ-026 The bench SHALL check defaults: binary=4095 at E0 -> busy high cycles 1..12; done in cycle 13 with bcd=16'h4095, overflow=0.
REQ-027 The bench SHALL check defaults: binary=0 -> bcd=16'h0000, overflow=0; then binary=999 -> bcd=16'h0999.
REQ-028 The bench SHALL check BIN_W=12, DIGITS=3: binary=1000 -> overflow=1, bcd=12'h000; binary=999 -> overflow=0, bcd=12'h999.
REQ-029 The bench SHALL check that binary=123 is accepted, and that start with binary=456 in cycle 5 is ignored, giving a single done with bcd=16'h0123.
REQ-030 The bench SHALL check that reset in cycle 6 of a conversion gives busy=0, bcd=0 and no done; a following start with 42 gives bcd=16'h0042 after 13 cycles.
REQ-031 The bench SHALL check that start held high continuously gives done every 13 cycles, with each result matching the binary value sampled at its accepting edge.
